sap_ram: RTL and testbench

Program/data memory for the SAP-1 core: 16 x 8 storage addressed by the 4-bit MAR output, read by the controller during run mode. Also contains a byte-serial loader with valid/ready handshake that fills all 16 locations in address order before a run. Sits between the MAR and the W-bus: the responder end of the MAR address path.

---
 rtl/sap_pkg.sv | 14 +
 rtl/sap_ram_if.sv | 28 ++
 rtl/sap_ram_loader.sv | 98 +++++++++
 rtl/sap_ram.sv | 78 +++++++
 tb/tb_sap_ram.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sap_pkg.sv
// Shared SAP-1 package: default widths, RAM depth and the RAM loader state type.
package sap_pkg;

  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 8;
  localparam int RAM_DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } ram_state_t;

endpackage

// File: rtl/sap_ram_if.sv
// Bus between the SAP-1 controller/loader (master) and sap_ram (slave):
// byte-serial loader handshake plus the MAR-addressed read path.
interface sap_ram_if #(
  parameter int ADDR_W = sap_pkg::ADDR_W,
  parameter int DATA_W = sap_pkg::DATA_W
);

  logic              prog_mode;
  logic              prog_valid;
  logic [DATA_W-1:0] prog_data;
  logic              prog_ready;
  logic              prog_done;
  logic [ADDR_W-1:0] marAddress;
  logic              CEram;
  logic [DATA_W-1:0] dataOut;
  logic              dataValid;

  modport master (
    output prog_mode, prog_valid, prog_data, marAddress, CEram,
    input  prog_ready, prog_done, dataOut, dataValid
  );

  modport slave (
    input  prog_mode, prog_valid, prog_data, marAddress, CEram,
    output prog_ready, prog_done, dataOut, dataValid
  );

endinterface

// File: rtl/sap_ram_loader.sv
// Loader FSM for sap_ram: walks IDLE -> LOAD -> DONE, accepts one byte per
// cycle in address order and emits write strobes into the storage array.
// SAP_RAM_CHECKSUM_EN adds a modulo-2^DATA_W sum of the accepted bytes.
module sap_ram_loader #(
  parameter int ADDR_W = sap_pkg::ADDR_W,
  parameter int DATA_W = sap_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_mode,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ready,
  output logic              prog_done,
  output logic              run_mode,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
`ifdef SAP_RAM_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] prog_checksum
`endif
);
  import sap_pkg::*;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'((2 ** ADDR_W) - 1);

  ram_state_t        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
`ifdef SAP_RAM_CHECKSUM_EN
  logic [DATA_W-1:0] cks_q, cks_d;
`endif

  // Handshake outputs are pure functions of the registered state.
  assign prog_ready = (state_q == LOAD);
  assign prog_done  = (state_q == DONE);
  assign run_mode   = (state_q == IDLE);
  assign wr_addr    = cnt_q;
  assign wr_data    = prog_data;
`ifdef SAP_RAM_CHECKSUM_EN
  assign prog_checksum = cks_q;
`endif

  // Next state: a beat is any prog_valid while in LOAD; dropping prog_mode
  // aborts even on the 16th beat (beat still written, DONE is skipped).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
`ifdef SAP_RAM_CHECKSUM_EN
    cks_d   = cks_q;
`endif
    case (state_q)
      IDLE: begin
        if (prog_mode) begin
          state_d = LOAD;
          cnt_d   = '0;
`ifdef SAP_RAM_CHECKSUM_EN
          cks_d   = '0;
`endif
        end
      end
      LOAD: begin
        if (prog_valid) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + 1'b1;
`ifdef SAP_RAM_CHECKSUM_EN
          cks_d = cks_q + prog_data;
`endif
        end
        if (!prog_mode)                       state_d = IDLE;
        else if (prog_valid && cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        if (!prog_mode) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and checksum registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
`ifdef SAP_RAM_CHECKSUM_EN
      cks_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef SAP_RAM_CHECKSUM_EN
      cks_q   <= cks_d;
`endif
    end
  end

endmodule

// File: rtl/sap_ram.sv
// SAP-1 program/data RAM: 2**ADDR_W x DATA_W storage, written only by the
// byte-serial loader, read with one-cycle latency in run mode via the MAR.
// SAP_RAM_CHECKSUM_EN exposes the loader checksum on prog_checksum.
module sap_ram #(
  parameter int ADDR_W = sap_pkg::ADDR_W,
  parameter int DATA_W = sap_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  sap_ram_if.slave          bus
`ifdef SAP_RAM_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] prog_checksum
`endif
);
  import sap_pkg::*;

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] mem_q;
  logic [DATA_W-1:0]            dout_q, dout_d;
  logic                         dval_q, dval_d;
  logic                         run_mode, wr_en;
  logic [ADDR_W-1:0]            wr_addr;
  logic [DATA_W-1:0]            wr_data;
  logic                         prog_ready, prog_done;

  sap_ram_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_loader (
    .clk        (clk),
    .rst_n      (rst_n),
    .prog_mode  (bus.prog_mode),
    .prog_valid (bus.prog_valid),
    .prog_data  (bus.prog_data),
    .prog_ready (prog_ready),
    .prog_done  (prog_done),
    .run_mode   (run_mode),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
`ifdef SAP_RAM_CHECKSUM_EN
    ,
    .prog_checksum (prog_checksum)
`endif
  );

  assign bus.prog_ready = prog_ready;
  assign bus.prog_done  = prog_done;
  assign bus.dataOut    = dout_q;
  assign bus.dataValid  = dval_q;

  // Storage: cleared by reset, written only by loader beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     mem_q <= '0;
    else if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  // Read port: only honoured in run mode; otherwise dataOut holds.
  always_comb begin
    dout_d = dout_q;
    dval_d = 1'b0;
    if (run_mode && bus.CEram) begin
      dout_d = mem_q[bus.marAddress];
      dval_d = 1'b1;
    end
  end

  // Registered read data and valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
      dval_q <= 1'b0;
    end else begin
      dout_q <= dout_d;
      dval_q <= dval_d;
    end
  end

endmodule

// File: tb/tb_sap_ram.sv
// Self-checking bench for sap_ram: randomized loader/read traffic checked
// against an array model of memory contents and handshake outcomes.
module tb_sap_ram;
  import sap_pkg::*;

  localparam int AW    = ADDR_W;
  localparam int DW    = DATA_W;
  localparam int DEPTH = RAM_DEPTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sap_ram_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
`ifdef SAP_RAM_CHECKSUM_EN
  logic [DW-1:0] cks;
`endif

  sap_ram #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef SAP_RAM_CHECKSUM_EN
    ,
    .prog_checksum (cks)
`endif
  );

  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] ref_mem [DEPTH];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Random-order read of every address, with occasional idle cycles
  // checking that dataOut holds and dataValid drops.
  task automatic test_readback(input string tag);
    int order [DEPTH];
    for (int i = 0; i < DEPTH; i++) order[i] = i;
    for (int i = DEPTH - 1; i > 0; i--) begin
      int j = $urandom_range(0, i);
      int t = order[i];
      order[i] = order[j];
      order[j] = t;
    end
    for (int i = 0; i < DEPTH; i++) begin
      bus.CEram = 1'b1;
      bus.marAddress = AW'(order[i]);
      tick();
      vectors++;
      if (bus.dataValid !== 1'b1 || bus.dataOut !== ref_mem[order[i]]) begin
        miscompares++;
        $display("FAIL %s read a%0d: got v=%b d=%h want v=1 d=%h", tag, order[i],
                 bus.dataValid, bus.dataOut, ref_mem[order[i]]);
      end
      if ($urandom_range(0, 3) == 0) begin
        bus.CEram = 1'b0;
        bus.marAddress = AW'($urandom);
        tick();
        vectors++;
        if (bus.dataValid !== 1'b0 || bus.dataOut !== ref_mem[order[i]]) begin
          miscompares++;
          $display("FAIL %s hold: got v=%b d=%h want v=0 d=%h", tag,
                   bus.dataValid, bus.dataOut, ref_mem[order[i]]);
        end
      end
    end
    bus.CEram = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    bus.prog_mode = 1'b0; bus.prog_valid = 1'b0; bus.prog_data = '0;
    bus.CEram = 1'b0; bus.marAddress = '0;
    rst_n = 1'b0;
    tick(); tick();
    vectors++;
    if ({bus.prog_ready, bus.prog_done, bus.dataValid} !== 3'b000 || bus.dataOut !== '0) begin
      miscompares++;
      $display("FAIL reset: got rdy=%b done=%b v=%b d=%h want 0 0 0 00",
               bus.prog_ready, bus.prog_done, bus.dataValid, bus.dataOut);
    end
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    bus.CEram = 1'b1; bus.marAddress = AW'(5);
    tick();
    vectors++;
    if (bus.dataValid !== 1'b1 || bus.dataOut !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_read5: got v=%b d=%h want v=1 d=00", bus.dataValid, bus.dataOut);
    end
    bus.CEram = 1'b0;
    tick();
    vectors++;
    if (bus.dataValid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle_valid: got %b want 0", bus.dataValid);
    end
  endtask

  task automatic test_stream();
    bus.prog_mode = 1'b1;
    #1;
    vectors++;
    if (bus.prog_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL stream_ready_early: got %b want 0", bus.prog_ready);
    end
    tick();
    vectors++;
    if (bus.prog_ready !== 1'b1 || bus.prog_done !== 1'b0) begin
      miscompares++;
      $display("FAIL stream_enter: got rdy=%b done=%b want 1 0", bus.prog_ready, bus.prog_done);
    end
    for (int i = 0; i < DEPTH; i++) begin
      bus.prog_valid = 1'b1;
      bus.prog_data = DW'(8'h10 + i);
      ref_mem[i] = DW'(8'h10 + i);
      tick();
      if (i < DEPTH - 1) begin
        vectors++;
        if (bus.prog_done !== 1'b0 || bus.prog_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL stream_beat%0d: got rdy=%b done=%b want 1 0", i, bus.prog_ready, bus.prog_done);
        end
      end
    end
    vectors++;
    if (bus.prog_done !== 1'b1 || bus.prog_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL stream_done: got rdy=%b done=%b want 0 1", bus.prog_ready, bus.prog_done);
    end
    // Extra beats in DONE must not touch memory.
    for (int i = 0; i < 3; i++) begin
      bus.prog_data = DW'($urandom);
      tick();
      vectors++;
      if (bus.prog_done !== 1'b1) begin
        miscompares++;
        $display("FAIL stream_done_hold: got %b want 1", bus.prog_done);
      end
    end
    bus.prog_valid = 1'b0;
    bus.prog_mode = 1'b0;
    tick();
    vectors++;
    if (bus.prog_done !== 1'b0 || bus.prog_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL stream_exit: got rdy=%b done=%b want 0 0", bus.prog_ready, bus.prog_done);
    end
    test_readback("stream");
  endtask

  // Loader with gaps: pattern 0 alternates valid, pattern 1 is random.
  task automatic test_gapped(input int pattern, input string tag);
    int k = 0;
    int cyc = 0;
    bus.prog_mode = 1'b1;
    tick();
    while (k < DEPTH && cyc < 200) begin
      logic v;
      logic [DW-1:0] d;
      v = (pattern == 0) ? (cyc % 2 == 0) : ($urandom_range(0, 9) < 6);
      d = DW'($urandom);
      bus.prog_valid = v;
      bus.prog_data = d;
      tick();
      if (v) begin
        ref_mem[k] = d;
        k++;
      end
      vectors++;
      if (bus.prog_done !== (k == DEPTH)) begin
        miscompares++;
        $display("FAIL %s done_at_cyc%0d: got %b want %b", tag, cyc, bus.prog_done, k == DEPTH);
      end
      cyc++;
    end
    if (k < DEPTH) begin
      vectors++;
      miscompares++;
      $display("FAIL %s timeout: got %0d beats want %0d", tag, k, DEPTH);
    end
    bus.prog_valid = 1'b0;
    bus.prog_mode = 1'b0;
    tick();
    test_readback(tag);
  endtask

  task automatic test_abort();
    bus.prog_mode = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      bus.prog_valid = 1'b1;
      bus.prog_data = DW'(8'hA0 + i);
      ref_mem[i] = DW'(8'hA0 + i);
      tick();
    end
    bus.prog_valid = 1'b0;
    bus.prog_mode = 1'b0;
    tick();
    vectors++;
    if (bus.prog_done !== 1'b0 || bus.prog_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL abort6: got rdy=%b done=%b want 0 0", bus.prog_ready, bus.prog_done);
    end
    test_readback("abort6");
  endtask

  // 16th beat arrives together with prog_mode dropping.
  task automatic test_abort_last();
    bus.prog_mode = 1'b1;
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      logic [DW-1:0] d = DW'($urandom);
      bus.prog_valid = 1'b1;
      bus.prog_data = d;
      ref_mem[i] = d;
      if (i == DEPTH - 1) bus.prog_mode = 1'b0;
      tick();
    end
    bus.prog_valid = 1'b0;
    vectors++;
    if (bus.prog_done !== 1'b0 || bus.prog_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_last: got rdy=%b done=%b want 0 0", bus.prog_ready, bus.prog_done);
    end
    tick();
    vectors++;
    if (bus.prog_done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_last_hold: got %b want 0", bus.prog_done);
    end
    test_readback("abort_last");
  endtask

  task automatic test_ce_during_load();
    logic [DW-1:0] held;
    bus.CEram = 1'b1;
    bus.marAddress = AW'(3);
    tick();
    held = ref_mem[3];
    bus.CEram = 1'b0;
    bus.prog_mode = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      logic [DW-1:0] d = DW'($urandom);
      bus.CEram = 1'b1;
      bus.marAddress = AW'($urandom);
      bus.prog_valid = 1'b1;
      bus.prog_data = d;
      ref_mem[i] = d;
      tick();
      vectors++;
      if (bus.dataValid !== 1'b0 || bus.dataOut !== held) begin
        miscompares++;
        $display("FAIL ce_in_load%0d: got v=%b d=%h want v=0 d=%h", i, bus.dataValid, bus.dataOut, held);
      end
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.prog_ready !== 1'b0 || bus.dataOut !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_load: got rdy=%b d=%h want 0 00", bus.prog_ready, bus.dataOut);
    end
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    bus.CEram = 1'b0; bus.prog_valid = 1'b0; bus.prog_mode = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    test_readback("rst_mid_load");
  endtask

`ifdef SAP_RAM_CHECKSUM_EN
  task automatic test_checksum(input int kind, input string tag);
    logic [DW-1:0] sum = '0;
    bus.prog_mode = 1'b1;
    tick();
    vectors++;
    if (cks !== '0) begin
      miscompares++;
      $display("FAIL %s cks_clear: got %h want 00", tag, cks);
    end
    for (int i = 0; i < DEPTH; i++) begin
      logic [DW-1:0] d = (kind == 0) ? DW'(8'h20) : DW'(i + 1);
      bus.prog_valid = 1'b1;
      bus.prog_data = d;
      ref_mem[i] = d;
      sum = sum + d;
      tick();
    end
    bus.prog_data = DW'(8'h55);
    tick();
    bus.prog_valid = 1'b0;
    vectors++;
    if (cks !== sum) begin
      miscompares++;
      $display("FAIL %s cks_done: got %h want %h", tag, cks, sum);
    end
    bus.prog_mode = 1'b0;
    tick(); tick();
    vectors++;
    if (cks !== sum) begin
      miscompares++;
      $display("FAIL %s cks_idle: got %h want %h", tag, cks, sum);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_gapped(0, "toggle");
    test_abort();
    test_abort_last();
    test_gapped(1, "b2b_a");
    test_gapped(1, "b2b_b");
    test_ce_during_load();
`ifdef SAP_RAM_CHECKSUM_EN
    test_checksum(1, "cks_ramp");
    test_checksum(0, "cks_wrap");
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
